// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter: FSM state encoding and
// the round-robin winner search.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    RELEASE
  } arb_state_t;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = 3;

  // First asserted request strictly after ptr, wrapping modulo n.
  function automatic logic [PTR_W-1:0] rr_first(
    input logic [MAX_REQ-1:0] req,
    input logic [PTR_W-1:0]   ptr,
    input int unsigned        n
  );
    logic [PTR_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        idx = (32'(ptr) + k) % n;
        if (!found && req[idx[PTR_W-1:0]]) begin
          win   = idx[PTR_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: one-hot winner among the requests, searching from the
// index after the pointer.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic             valid
);

  logic [PTR_W-1:0] win_idx;

  always_comb begin
    win_idx = rr_first(MAX_REQ'(req), ptr, N_REQ);
    win_oh  = N_REQ'(1) << win_idx;
    valid   = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-oriented round-robin arbiter feeding N_REQ write requesters into one
// FIFO write port, with free-space admission and an in-burst idle timeout.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WIDTH = 8,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            s_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_data,
  output logic [N_REQ-1:0]            s_ready,
  output logic [N_REQ-1:0]            gnt,
  output logic                        fifo_w_en,
  output logic [DATA_WIDTH-1:0]       fifo_wdata,
  input  logic                        fifo_wfull,
  input  logic [DEPTH_WIDTH:0]        fifo_wr_water_level,
  output logic                        err_timeout
);

  localparam int unsigned     CW          = DEPTH_WIDTH + 2;
  localparam int unsigned     TW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   DEPTH_WORDS = CW'(1) << DEPTH_WIDTH;
  localparam logic [CW-1:0]   BURST_WORDS = CW'(BURST_LEN);
  localparam logic [TW-1:0]   IDLE_LAST   = TW'(TIMEOUT - 1);

  arb_state_t       state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt, pick_oh;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt, owner, owner_nxt, pick_idx;
  logic [CW-1:0]    beat_cnt, beat_cnt_nxt, free_words;
  logic [TW-1:0]    idle_cnt, idle_cnt_nxt;
  logic             err_nxt, pick_valid, space_ok, beat;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .win_oh (pick_oh),
    .valid  (pick_valid)
  );

  assign s_ready    = gnt & {N_REQ{~fifo_wfull}};
  assign beat       = |(s_valid & s_ready);
  assign fifo_w_en  = beat;
  assign free_words = DEPTH_WORDS - CW'(fifo_wr_water_level);
  assign space_ok   = free_words >= BURST_WORDS;

  always_comb begin
    fifo_wdata = '0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) fifo_wdata = fifo_wdata | s_data[i*DATA_WIDTH +: DATA_WIDTH];
      if (pick_oh[i]) pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    idle_cnt_nxt = idle_cnt;
    err_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid && space_ok) begin
          state_nxt    = BURST;
          gnt_nxt      = pick_oh;
          owner_nxt    = pick_idx;
          beat_cnt_nxt = '0;
          idle_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (beat) begin
          idle_cnt_nxt = '0;
          if (beat_cnt == BURST_WORDS - CW'(1)) begin
            state_nxt = RELEASE;
            gnt_nxt   = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + CW'(1);
          end
        end else if (!fifo_wfull) begin
          // A full FIFO is back-pressure, not requester silence.
          if (idle_cnt == IDLE_LAST) begin
            state_nxt = RELEASE;
            gnt_nxt   = '0;
            err_nxt   = 1'b1;
          end else begin
            idle_cnt_nxt = idle_cnt + TW'(1);
          end
        end
      end
      RELEASE: begin
        state_nxt    = IDLE;
        rr_ptr_nxt   = owner;
        beat_cnt_nxt = '0;
        idle_cnt_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      rr_ptr      <= PTR_W'(N_REQ - 1);
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      owner       <= owner_nxt;
      rr_ptr      <= rr_ptr_nxt;
      beat_cnt    <= beat_cnt_nxt;
      idle_cnt    <= idle_cnt_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a transaction-level
// model of grants, burst words, dead cycles and timeouts.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int DEP = 8;
  localparam int BL  = 8;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, s_valid, s_ready, gnt;
  logic [N*DW-1:0] s_data;
  logic            fifo_w_en, fifo_wfull, err_timeout;
  logic [DW-1:0]   fifo_wdata;
  logic [DEP:0]    level;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .DEPTH_WIDTH(DEP), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req                 (req),
    .s_valid             (s_valid),
    .s_data              (s_data),
    .s_ready             (s_ready),
    .gnt                 (gnt),
    .fifo_w_en           (fifo_w_en),
    .fifo_wdata          (fifo_wdata),
    .fifo_wfull          (fifo_wfull),
    .fifo_wr_water_level (level),
    .err_timeout         (err_timeout)
  );

  int errors = 0;
  int checks = 0;

  // Model: owner of the current burst (-1 none), words done, silent-cycle run,
  // pending dead cycle, last owner served.
  int          cur, done_w, idle_run, last_owner;
  bit          dead, err_exp;
  logic [15:0] seq [N];
  logic [DW-1:0] wq [$];
  int          gorder [$];
  int          err_pulses;
  logic [N-1:0] prev_gnt;

  always_comb
    for (int i = 0; i < N; i++) s_data[i*DW +: DW] = {8'(i), 8'h00, seq[i]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = -1; done_w = 0; idle_run = 0; last_owner = N - 1; dead = 0; err_exp = 0;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    req = '0; s_valid = '0; fifo_wfull = 1'b0; level = '0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    wq.delete(); gorder.delete();
    err_pulses = 0; prev_gnt = '0;
    for (int i = 0; i < N; i++) seq[i] = '0;
  endtask

  task automatic cyc();
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    bit            b;
    int            who, free;
    @(negedge clk);
    eg = '0; ed = '0; b = 0; who = -1;
    if (cur >= 0) begin
      eg = N'(1) << cur;
      ed = {8'(cur), 8'h00, seq[cur]};
      b  = !fifo_wfull && s_valid[cur];
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("s_ready", 64'(s_ready), fifo_wfull ? 64'd0 : 64'(eg));
    chk("w_en", 64'(fifo_w_en), 64'(b));
    chk("wdata", 64'(fifo_wdata), 64'(ed));
    chk("err_timeout", 64'(err_timeout), 64'(err_exp));
    if (fifo_w_en) wq.push_back(fifo_wdata);
    if (err_timeout) err_pulses++;
    if (gnt != '0 && prev_gnt == '0)
      for (int i = 0; i < N; i++) if (gnt[i]) gorder.push_back(i);
    prev_gnt = gnt;

    err_exp = 0;
    if (cur >= 0) begin
      bit fin = 0;
      if (b) begin
        who = cur; done_w++; idle_run = 0;
        if (done_w == BL) fin = 1;
      end else if (!fifo_wfull) begin
        idle_run++;
        if (idle_run == TO) begin fin = 1; err_exp = 1; end
      end
      if (fin) begin last_owner = cur; cur = -1; dead = 1; end
    end else if (dead) begin
      dead = 0;
    end else begin
      free = (1 << DEP) - int'(level);
      if (req != '0 && free >= BL) begin
        for (int k = N; k >= 1; k--)
          if (req[(last_owner + k) % N]) cur = (last_owner + k) % N;
        done_w = 0; idle_run = 0;
      end
    end
    @(posedge clk); #1;
    if (who >= 0) seq[who]++;
  endtask

  initial begin
    int r0;
    rst_n = 1'b0;
    req = '0; s_valid = '0; fifo_wfull = 1'b0; level = '0;
    for (int i = 0; i < N; i++) seq[i] = '0;
    model_reset();
    prev_gnt = '0; err_pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_w_en", 64'(fifo_w_en), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    rst_n = 1'b1;

    // Two requesters, continuous valid: 0 then 2, eight words each.
    restart();
    req = 4'b0101; s_valid = '1;
    repeat (20) cyc();
    chk("alt_words", 64'(wq.size()), 64'd16);
    chk("alt_bursts", 64'(gorder.size()), 64'd2);
    if (gorder.size() == 2) begin
      chk("alt_first", 64'(gorder[0]), 64'd0);
      chk("alt_second", 64'(gorder[1]), 64'd2);
    end

    // All requesting: four bursts in index order, words in order.
    restart();
    req = '1; s_valid = '1;
    repeat (40) cyc();
    chk("rr_words", 64'(wq.size()), 64'd32);
    if (wq.size() == 32)
      for (int k = 0; k < 32; k++)
        chk("rr_word", 64'(wq[k]), 64'({8'(k / 8), 8'h00, 16'(k % 8)}));
    chk("rr_bursts", 64'(gorder.size()), 64'd4);
    if (gorder.size() == 4)
      for (int k = 0; k < 4; k++) chk("rr_order", 64'(gorder[k]), 64'(k));

    // Free-space admission threshold.
    restart();
    req = 4'b0010; s_valid = '1; level = 9'd250;
    repeat (6) cyc();
    level = 9'd249;
    repeat (3) cyc();
    chk("space_hold", 64'(gorder.size()), 64'd0);
    level = 9'd248;
    repeat (2) cyc();
    chk("space_grant", 64'(gnt), 64'b0010);

    // Timeout after three beats, then next requester.
    restart();
    req = 4'b0011; s_valid = '1;
    repeat (4) cyc();
    s_valid[0] = 1'b0;
    repeat (16) cyc();
    s_valid = '1;
    repeat (12) cyc();
    chk("to_pulses", 64'(err_pulses), 64'd1);
    r0 = 0;
    foreach (wq[k]) if (wq[k][31:24] == 8'd0) r0++;
    chk("to_r0_words", 64'(r0), 64'd3);
    chk("to_bursts", 64'(gorder.size()), 64'd2);
    if (gorder.size() == 2) chk("to_next", 64'(gorder[1]), 64'd1);

    // Full stall mid-burst; req dropped after grant.
    restart();
    req = 4'b0001; s_valid = '1;
    cyc();
    req = '0;
    repeat (3) cyc();
    fifo_wfull = 1'b1;
    repeat (5) cyc();
    chk("full_stall_words", 64'(wq.size()), 64'd3);
    fifo_wfull = 1'b0;
    repeat (8) cyc();
    chk("full_words", 64'(wq.size()), 64'd8);
    chk("full_no_err", 64'(err_pulses), 64'd0);

    // Asynchronous reset during beat 4.
    restart();
    req = 4'b0001; s_valid = '1;
    repeat (4) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 64'(gnt), 64'd0);
    chk("arst_w_en", 64'(fifo_w_en), 64'd0);
    model_reset();
    gorder.delete(); prev_gnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req = '1;
    repeat (3) cyc();
    chk("arst_first", 64'(gorder.size() > 0 ? gorder[0] : -1), 64'd0);

    // Randomized traffic with quiet phases to provoke timeouts.
    restart();
    for (int c = 0; c < 500; c++) begin
      req        = N'($urandom_range(0, 15));
      s_valid    = ((c / 40) % 3 == 2) ? '0 : N'($urandom_range(0, 15) | $urandom_range(0, 15));
      fifo_wfull = ($urandom_range(0, 6) == 0);
      level      = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(244, 256))
                                                : 9'($urandom_range(0, 256));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
